seq_mul: RTL and testbench

- Iterative unsigned shift-add multiplier, the inverse operation of the combinational divider datapath.
- Computes product = multiplicand × multiplier over WIDTH clock cycles, using one adder and shift registers.
- Serves as the reconstruction/check path for the division unit: quotient × divisor (+ remainder externally) regenerates the dividend.
- Operand input and result output each use a valid/ready handshake.

---
 rtl/seq_mul.sv | 94 +++++++++
 tb/tb_seq_mul.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul.sv
// Iterative unsigned shift-add multiplier with valid/ready handshakes on both sides.
// Define SEQ_MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   accumuland;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_next;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mplier_next;
    logic [CW-1:0]   cnt;
    logic            last;

    assign in_ready = (state == IDLE) && !rst;

    // One partial product per BUSY edge, selected by the current LSB of the multiplier.
    always_comb begin
        acc_next    = mplier[0] ? (acc + accumuland) : acc;
        mplier_next = mplier >> 1;
`ifdef SEQ_MUL_EARLY_TERM_EN
        last        = (mplier_next == '0);
`else
        last        = (cnt == CW'(WIDTH - 1));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            product    <= '0;
            zero       <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            accumuland <= '0;
            mplier     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        accumuland <= {{WIDTH{1'b0}}, in_a};
                        mplier     <= in_b;
                        acc        <= '0;
                        cnt        <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    acc        <= acc_next;
                    accumuland <= accumuland << 1;
                    mplier     <= mplier_next;
                    cnt        <= cnt + CW'(1);
                    if (last) begin
                        product   <= acc_next;
                        zero      <= (acc_next == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Result is held under backpressure; a new pair waits for IDLE.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul: driver pushes expected results, monitor pops on each output.
module tb_seq_mul;

    localparam int WIDTH = 8;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 zero;

    seq_mul #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .zero      (zero)
    );

    typedef struct {
        logic [2*WIDTH-1:0] p;
        logic               z;
        int                 acc_cyc;
        int                 lat;
    } exp_t;

    typedef struct {
        int a;
        int b;
        int p;
        int z;
        int lat_early;
    } vec_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int lat_early);
`ifdef SEQ_MUL_EARLY_TERM_EN
        return lat_early;
`else
        return WIDTH;
`endif
    endfunction

    // Monitor: every presented result is matched against the oldest expectation.
    initial begin : monitor
        bit                 holding;
        logic [2*WIDTH-1:0] hp;
        logic               hz;
        exp_t               e;
        holding = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                holding = 1'b0;
            end else if (out_valid) begin
                if (!holding) begin
                    holding = 1'b1;
                    if (q.size() == 0) begin
                        chk("unexpected_result", longint'(product), -1);
                    end else begin
                        e = q.pop_front();
                        chk("product", longint'(product), longint'(e.p));
                        chk("zero", longint'(zero), longint'(e.z));
                        chk("latency", cyc - e.acc_cyc, e.lat);
                    end
                    hp = product;
                    hz = zero;
                end else begin
                    chk("hold_product", longint'(product), longint'(hp));
                    chk("hold_zero", longint'(zero), longint'(hz));
                end
                if (out_ready) holding = 1'b0;
            end
        end
    end

    // Entered and left at posedge+1; returns after the accepting edge.
    task automatic issue(input int a, input int b, input int p, input int z, input int lat, input bit push);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_a = WIDTH'(a);
        in_b = WIDTH'(b);
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                if (push) begin
                    e.p = (2*WIDTH)'(p);
                    e.z = z[0];
                    e.acc_cyc = cyc + 1;
                    e.lat = lat;
                    q.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    // Waits for out_valid, checking in_ready stays low; consumes the result if out_ready=1.
    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else chk("in_ready_busy", longint'(in_ready), 0);
        end
        if (!seen) chk("done_timeout", 0, 1);
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    vec_t vecs[$] = '{
        '{13,  11,  143,   0, 4},
        '{255, 255, 65025, 0, 8},
        '{0,   200, 0,     1, 8},
        '{200, 0,   0,     1, 1},
        '{50,  1,   50,    0, 1},
        '{50,  128, 6400,  0, 8},
        '{1,   255, 255,   0, 8},
        '{255, 1,   255,   0, 1}
    };

    initial begin : driver
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_product", longint'(product), 0);
        chk("rst_zero", longint'(zero), 0);
        chk("rst_in_ready", longint'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].z, lat_of(vecs[i].lat_early), 1'b1);
            wait_done();
        end

        // Backpressure: result held 5 extra cycles while a new pair is offered.
        out_ready = 1'b0;
        issue(20, 30, 600, 0, lat_of(5), 1'b1);
        wait_done();
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a = 8'd6;
        in_b = 8'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", longint'(out_valid), 1);
            chk("bp_in_ready", longint'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_last", longint'(in_ready), 0);
        @(posedge clk);
        #1;
        begin
            exp_t e;
            @(negedge clk);
            chk("bp_in_ready_idle", longint'(in_ready), 1);
            e.p = 16'd42;
            e.z = 1'b0;
            e.acc_cyc = cyc + 1;
            e.lat = lat_of(3);
            q.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        wait_done();

        // Reset during the 4th BUSY edge discards 100x3.
        issue(100, 3, 300, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_product", longint'(product), 0);
        chk("midrst_in_ready", longint'(in_ready), 1);
        repeat (10) @(posedge clk);
        #1;
        issue(7, 9, 63, 0, lat_of(4), 1'b1);
        wait_done();

        repeat (3) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
